m_int_responder: RTL
====================

M_INT_RESPONDER -- requirements
Module: m_int_responder

Interface
REQ-001 SHALL have port MasterClock, input, 1, the only clock; all state changes on its rising edge.
REQ-002 SHALL have port RESETL, input, 1, synchronous active-low reset, sampled on MasterClock.
REQ-003 SHALL have port src_req, input, 4, one-clock set strobes, one per source; bit 0 is highest priority.
REQ-004 SHALL have port src_en, input, 4, per-source enable mask.
REQ-005 SHALL have port vec_base, input, 8, vector base; bits [7:3] are used.
REQ-006 SHALL have port INTAL, input, 1, CPU interrupt-acknowledge, active-low; two low pulses per acknowledge.
REQ-007 SHALL have port eoi / eoi_src, input, 1 / 2, one-clock end-of-interrupt strobe and source index.
REQ-008 SHALL have port INTR, output, 1, interrupt request to the CPU, registered.
REQ-009 SHALL have port vec_out / vec_oe, output, 8 / 1, vector byte and bus drive enable, registered.
REQ-010 SHALL have port pending / in_service, output, 4 / 4, latch status for register readback.

Function
REQ-011 pending[i] SHALL set on src_req[i]; it clears only on second-INTA acceptance of source i; set wins over a simultaneous clear.
REQ-012 Winner SHALL be the lowest i with pending[i] & src_en[i] and not blocked by in_service (REQ-024).
REQ-013 INTR SHALL be 1 the cycle after a winner exists in IDLE, and 0 the cycle after the first INTAL low sample.
REQ-014 FSM states SHALL be IDLE, ACK1, GAP, ACK2.
- IDLE->ACK1: INTAL sampled low.
- ACK1->GAP: INTAL sampled high.
- GAP->ACK2: INTAL sampled low.
- ACK2->IDLE: INTAL sampled high.
REQ-015 On entry to ACK1 the winner index SHALL be frozen; later src_req or src_en changes do not alter the vector.
REQ-016 If no winner exists at entry to ACK1, the frozen index SHALL be 3'b111 (spurious).
REQ-017 On entry to ACK2, vec_out SHALL be {vec_base[7:3], idx} and vec_oe SHALL be 1 one clock after INTAL is first sampled low; vec_oe SHALL stay 1 throughout ACK2.
REQ-018 vec_oe SHALL drop to 0 the cycle after INTAL is sampled high in ACK2; vec_oe SHALL be 0 in every other state.
REQ-019 On entry to ACK2 with a non-spurious idx: pending[idx] SHALL clear and in_service[idx] SHALL set.
REQ-020 A spurious acknowledge SHALL change no pending or in_service bit.
REQ-021 eoi SHALL clear in_service[eoi_src] in any state; eoi for a bit that is not set SHALL have no effect.
REQ-022 In IDLE, INTAL sampled low with INTR=0 SHALL still run the full sequence and yield the spurious vector.

Reset
REQ-023 When RESETL is sampled low, in any state (including mid-acknowledge), the block SHALL on the next edge enter IDLE and set INTR=0, vec_oe=0, vec_out=8'h00, pending=0, in_service=0.

Configuration
REQ-024 Macro INT_NESTING_EN SHALL select the in_service blocking rule.
- Defined: source i is blocked only if any in_service[j] with j<=i is set, so higher priority nests.
- Undefined: any set in_service bit blocks all sources.

Structure
REQ-025 Package m_int_pkg SHALL hold NUM_SRC=4, SPURIOUS_IDX=3'b111 and the FSM state enum.
REQ-026 The priority encoder SHALL be sub-module m_int_prio (combinational: masked request in, valid and index out).

Verification
REQ-027 vec_base=8'h40, src_req[2] pulse, src_en=4'hF, two INTAL pulses -> INTR=1, then vec_out=8'h42 with vec_oe=1 during 2nd pulse only; pending=0, in_service=4'b0100.
REQ-028 src_req[3] and src_req[1] in the same cycle -> vector 8'h41 first; after eoi_src=1, a second acknowledge -> 8'h43.
REQ-029 src_en cleared to 0 between INTR and the first INTAL -> vector 8'h47; pending unchanged.
REQ-030 in_service[2] set, src_req[0] -> INTR=1 with INT_NESTING_EN defined; INTR=0 without it until eoi_src=2.
REQ-031 RESETL low during ACK2 -> next edge: vec_oe=0, FSM IDLE, all status 0; src_req[2] and a pending clear in the same cycle -> pending[2]=1.

Source files
------------

// File: rtl/m_int_pkg.sv
// Shared definitions for the interrupt responder: source count, spurious
// index, acknowledge FSM states and the in-service blocking rule.
// Optional feature macro: INT_NESTING_EN (nested priority servicing).
package m_int_pkg;

    localparam int NUM_SRC = 4;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } m_int_state_e;

    // Returns a per-source mask of sources currently blocked by in-service bits.
    function automatic logic [NUM_SRC-1:0] blockMask(input logic [NUM_SRC-1:0] inService);
        logic [NUM_SRC-1:0] blk;
`ifdef INT_NESTING_EN
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Source i is blocked when it or any higher-priority source is in service.
            acc = acc | inService[i];
            blk[i] = acc;
        end
`else
        // Any source in service blocks everything until its end-of-interrupt.
        blk = {NUM_SRC{|inService}};
`endif
        return blk;
    endfunction

endpackage

// File: rtl/m_int_prio.sv
// Fixed-priority encoder: bit 0 of the masked request vector wins.
module m_int_prio
    import m_int_pkg::*;
(
    input  logic [NUM_SRC-1:0] maskedReq,
    output logic               winValid,
    output logic [1:0]         winIdx
);

    // Scan from lowest priority upward so the lowest set index is the last write.
    always_comb begin
        winValid = 1'b0;
        winIdx   = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (maskedReq[i]) begin
                winValid = 1'b1;
                winIdx   = 2'(i);
            end
        end
    end

endmodule

// File: rtl/m_int_responder.sv
// Four-source interrupt responder with a two-pulse INTA acknowledge sequence.
// The winning source index is frozen on the first INTA pulse and presented as
// {vec_base[7:3], idx} while the second pulse is low.
// Optional feature macro: INT_NESTING_EN (higher priority may nest over
// lower-priority in-service sources; otherwise any in-service source blocks all).
//
// dbgState mirrors the acknowledge FSM state for observation.
module m_int_responder
    import m_int_pkg::*;
(
    input  logic               MasterClock,
    input  logic               RESETL,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic [7:0]         vec_base,
    input  logic               INTAL,
    input  logic               eoi,
    input  logic [1:0]         eoi_src,
    output logic               INTR,
    output logic [7:0]         vec_out,
    output logic               vec_oe,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service,
    output m_int_state_e       dbgState
);

    m_int_state_e       state;
    m_int_state_e       stateNext;
    logic               ack1Entry;
    logic               ack2Entry;
    logic [NUM_SRC-1:0] maskedReq;
    logic               winValid;
    logic [1:0]         winIdx;
    logic [IDX_W-1:0]   idxQ;
    logic [NUM_SRC-1:0] acceptMask;
    logic [NUM_SRC-1:0] eoiMask;

    assign dbgState  = state;
    assign maskedReq = pending & src_en & ~blockMask(in_service);

    m_int_prio uPrio (
        .maskedReq (maskedReq),
        .winValid  (winValid),
        .winIdx    (winIdx)
    );

    // Next-state logic: each INTAL level change advances one step of the sequence.
    always_comb begin
        stateNext = state;
        ack1Entry = 1'b0;
        ack2Entry = 1'b0;
        case (state)
            IDLE: if (!INTAL) begin
                stateNext = ACK1;
                ack1Entry = 1'b1;
            end
            ACK1: if (INTAL) stateNext = GAP;
            GAP: if (!INTAL) begin
                stateNext = ACK2;
                ack2Entry = 1'b1;
            end
            ACK2: if (INTAL) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Acceptance clears pending and sets in-service only for a real source.
    always_comb begin
        acceptMask = '0;
        eoiMask    = '0;
        if (ack2Entry && (idxQ != SPURIOUS_IDX)) acceptMask[idxQ[1:0]] = 1'b1;
        if (eoi) eoiMask[eoi_src] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge MasterClock) begin
        if (!RESETL) state <= IDLE;
        else         state <= stateNext;
    end

    // INTR is raised only while idle with a winner and dropped on the first INTA low.
    always_ff @(posedge MasterClock) begin
        if (!RESETL) INTR <= 1'b0;
        else         INTR <= (state == IDLE) && INTAL && winValid;
    end

    // Freeze the winner at the first INTA pulse; no winner means spurious.
    always_ff @(posedge MasterClock) begin
        if (!RESETL)        idxQ <= SPURIOUS_IDX;
        else if (ack1Entry) idxQ <= winValid ? {1'b0, winIdx} : SPURIOUS_IDX;
    end

    // Vector drive: enabled for exactly the cycles spent in ACK2.
    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            vec_oe  <= 1'b0;
            vec_out <= 8'h00;
        end else begin
            vec_oe <= (stateNext == ACK2);
            if (ack2Entry) vec_out <= {vec_base[7:3], idxQ};
        end
    end

    // Status latches: a new request wins over acceptance; a new acceptance wins over eoi.
    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= (pending & ~acceptMask) | src_req;
            in_service <= (in_service & ~eoiMask) | acceptMask;
        end
    end

endmodule
